pending_encoder: RTL and testbench

Sequential priority encoder that converts sparse event pulses into a stream of binary codes. Each request line latches into a sticky pending register; pending events are issued one per handshake, lowest index first, on a valid/ready output. It is the inverse of the team's enable-gated decoders and uses the same code map: request bit i ↔ code i+1, and code 0 = "no event". Typical use is an interrupt/event source feeding a decoder-driven consumer.

---
 rtl/pending_encoder.sv | 155 +++++++++++++++
 tb/tb_pending_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pending_encoder.sv
// Sequential priority encoder: sticky pending events are issued one per
// valid/ready handshake, lowest index first, as code = index + 1.
module pending_encoder #(
  parameter  int CODE_W = 4,
  localparam int REQ_W  = (2 ** CODE_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [REQ_W-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code_out,
  output logic              valid,
  output logic [REQ_W-1:0]  pending,
  output logic [7:0]        coalesce_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [REQ_W-1:0]    pending_r;
  logic [REQ_W-1:0]    pending_nxt_s;
  logic [REQ_W-1:0]    clr_s;
  logic [REQ_W-1:0]    hits_s;
  logic [CODE_W-1:0]   code_r;
  logic [CODE_W-1:0]   code_nxt_s;
  logic [CODE_W-1:0]   sel_code_s;
  logic                valid_r;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_nxt_s;
  logic [8:0]          cnt_sum_s;
  logic                issue_ok_s;
  logic                load_s;

  // One-hot mask of the lowest set bit (all zeros when v is empty).
  function automatic logic [REQ_W-1:0] lowest_onehot(input logic [REQ_W-1:0] v);
    logic [REQ_W-1:0] r;
    r = '0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      r = v[i] ? (REQ_W'(1) << i) : r;
    end
    return r;
  endfunction

  // Code of the lowest set bit: index i maps to i + 1, empty maps to 0.
  function automatic logic [CODE_W-1:0] lowest_code(input logic [REQ_W-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      c = v[i] ? CODE_W'(i + 1) : c;
    end
    return c;
  endfunction

  // Number of set bits; REQ_W < 2**CODE_W so CODE_W bits always suffice.
  function automatic logic [CODE_W-1:0] popcount(input logic [REQ_W-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < REQ_W; i++) begin
      c = c + CODE_W'(v[i]);
    end
    return c;
  endfunction

  // Next-state and next-code selection for the issue state machine.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    load_s      = 1'b0;
    sel_code_s  = lowest_code(pending_r);
    issue_ok_s  = enable && (pending_r != '0);
    case (state_r)
      IDLE: begin
        if (issue_ok_s) begin
          load_s      = 1'b1;
          state_nxt_s = SEND;
          code_nxt_s  = sel_code_s;
        end else begin
          state_nxt_s = IDLE;
          code_nxt_s  = '0;
        end
      end
      SEND: begin
        if (ready) begin
          if (issue_ok_s) begin
            load_s      = 1'b1;
            state_nxt_s = SEND;
            code_nxt_s  = sel_code_s;
          end else begin
            state_nxt_s = IDLE;
            code_nxt_s  = '0;
          end
        end else begin
          state_nxt_s = SEND;
          code_nxt_s  = code_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        code_nxt_s  = '0;
      end
    endcase
  end

  // Pending capture (set wins over clear) and saturating coalesce count.
  always_comb begin
    clr_s         = '0;
    hits_s        = '0;
    pending_nxt_s = pending_r;
    cnt_sum_s     = {1'b0, cnt_r};
    cnt_nxt_s     = cnt_r;
    if (load_s) begin
      clr_s = lowest_onehot(pending_r);
    end else begin
      clr_s = '0;
    end
    if (enable) begin
      hits_s        = req & pending_r & ~clr_s;
      pending_nxt_s = (pending_r & ~clr_s) | req;
      cnt_sum_s     = {1'b0, cnt_r} + 9'(popcount(hits_s));
      cnt_nxt_s     = cnt_sum_s[8] ? 8'hFF : cnt_sum_s[7:0];
    end else begin
      hits_s        = '0;
      pending_nxt_s = pending_r;
      cnt_nxt_s     = cnt_r;
    end
  end

  // State, code, pending and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      code_r    <= '0;
      valid_r   <= 1'b0;
      pending_r <= '0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      code_r    <= code_nxt_s;
      valid_r   <= (state_nxt_s == SEND);
      pending_r <= pending_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign code_out     = code_r;
  assign valid        = valid_r;
  assign pending      = pending_r;
  assign coalesce_cnt = cnt_r;

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder: a cycle-level event model is compared
// against the DUT every cycle, with hand-computed expectations at key points.
module tb_pending_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [14:0] req;
  logic        ready;
  logic [3:0]  code_out;
  logic        valid;
  logic [14:0] pending;
  logic [7:0]  coalesce_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 1'b0;

  typedef struct packed {
    logic [14:0] pend;
    logic [3:0]  code;
    logic        vld;
    logic [7:0]  cnt;
  } mstate_t;

  mstate_t m = '0;

  pending_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .ready        (ready),
    .code_out     (code_out),
    .valid        (valid),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Event-level model: which event is outstanding, which are waiting, and how
  // many requests landed on an event that was already waiting.
  function automatic mstate_t model_next(input mstate_t s, input logic rn, input logic en,
                                         input logic [14:0] rq, input logic rdy);
    mstate_t n;
    int      sel;
    int      cnt;
    bit      accepted;
    bit      issue;
    if (!rn) return '0;
    n   = s;
    sel = -1;
    for (int i = 14; i >= 0; i--) if (s.pend[i]) sel = i;
    accepted = s.vld && rdy;
    issue    = en && (sel >= 0) && (!s.vld || accepted);
    if (issue) begin
      n.vld       = 1'b1;
      n.code      = 4'(sel + 1);
      n.pend[sel] = 1'b0;
    end else if (accepted) begin
      n.vld  = 1'b0;
      n.code = 4'd0;
    end
    if (en) begin
      cnt = int'(s.cnt);
      for (int i = 0; i < 15; i++) begin
        if (rq[i]) begin
          if (s.pend[i] && !(issue && i == sel)) cnt = (cnt < 255) ? cnt + 1 : 255;
          n.pend[i] = 1'b1;
        end
      end
      n.cnt = 8'(cnt);
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst_n, enable, req, ready);

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model code_out", 32'(code_out), 32'(m.code));
      chk("model valid", 32'(valid), 32'(m.vld));
      chk("model pending", 32'(pending), 32'(m.pend));
      chk("model coalesce_cnt", 32'(coalesce_cnt), 32'(m.cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    ready  = 1'b0;
    req    = 15'h7FFF;
    cyc();
    cyc();
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset code", 32'(code_out), 32'h0);
    chk("reset cnt", 32'(coalesce_cnt), 32'h0);
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    req    = 15'h0000;
    cyc();

    // single event
    ready = 1'b1;
    req   = 15'h0004;
    cyc();
    req = 15'h0000;
    chk("single pending set", 32'(pending), 32'h4);
    chk("single valid early", 32'(valid), 32'h0);
    cyc();
    chk("single valid", 32'(valid), 32'h1);
    chk("single code", 32'(code_out), 32'd3);
    chk("single pending clr", 32'(pending), 32'h0);
    cyc();
    chk("single valid drop", 32'(valid), 32'h0);
    chk("single code zero", 32'(code_out), 32'h0);

    // priority with backpressure
    ready = 1'b0;
    req   = 15'h4081;
    cyc();
    req = 15'h0000;
    chk("prio pending", 32'(pending), 32'h4081);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("prio hold valid", 32'(valid), 32'h1);
      chk("prio hold code", 32'(code_out), 32'd1);
    end
    ready = 1'b1;
    cyc();
    chk("prio code 8", 32'(code_out), 32'd8);
    cyc();
    chk("prio code 15", 32'(code_out), 32'd15);
    chk("prio pending empty", 32'(pending), 32'h0);
    cyc();
    chk("prio valid drop", 32'(valid), 32'h0);

    // set wins over clear
    req = 15'h0001;
    cyc();
    chk("coll pending", 32'(pending), 32'h1);
    cyc();
    req = 15'h0000;
    chk("coll code first", 32'(code_out), 32'd1);
    chk("coll bit kept", 32'(pending), 32'h1);
    chk("coll cnt", 32'(coalesce_cnt), 32'h0);
    cyc();
    chk("coll code second", 32'(code_out), 32'd1);
    chk("coll valid second", 32'(valid), 32'h1);
    chk("coll pending clr", 32'(pending), 32'h0);
    cyc();
    chk("coll valid drop", 32'(valid), 32'h0);
    chk("coll cnt after", 32'(coalesce_cnt), 32'h0);

    // coalesce saturation while code 2 is held
    ready = 1'b0;
    req   = 15'h0002;
    cyc();
    req = 15'h0000;
    cyc();
    chk("sat code 2", 32'(code_out), 32'd2);
    req = 15'h0020;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (k == 0) chk("sat first pulse cnt", 32'(coalesce_cnt), 32'd0);
      if (k == 1) chk("sat second pulse cnt", 32'(coalesce_cnt), 32'd1);
      if (k == 254) chk("sat cnt 254", 32'(coalesce_cnt), 32'd254);
      if (k == 255) chk("sat cnt 255", 32'(coalesce_cnt), 32'd255);
    end
    req = 15'h0000;
    chk("sat cnt final", 32'(coalesce_cnt), 32'd255);
    chk("sat pending", 32'(pending), 32'h0020);
    chk("sat code held", 32'(code_out), 32'd2);
    ready = 1'b1;
    cyc();
    chk("sat drain code 6", 32'(code_out), 32'd6);
    cyc();
    chk("sat drain valid", 32'(valid), 32'h0);

    // enable freeze with a code in flight
    ready = 1'b0;
    req   = 15'h0008;
    cyc();
    req = 15'h0000;
    cyc();
    chk("frz code 4", 32'(code_out), 32'd4);
    enable = 1'b0;
    req    = 15'h0010;
    ready  = 1'b1;
    cyc();
    req = 15'h0000;
    chk("frz valid drop", 32'(valid), 32'h0);
    chk("frz no capture", 32'(pending), 32'h0);
    chk("frz cnt hold", 32'(coalesce_cnt), 32'd255);
    enable = 1'b1;
    req    = 15'h0010;
    cyc();
    req = 15'h0000;
    chk("frz recapture", 32'(pending), 32'h0010);
    cyc();
    chk("frz code 5", 32'(code_out), 32'd5);
    cyc();
    chk("frz idle", 32'(valid), 32'h0);

    // enable freeze with an event waiting
    req = 15'h0100;
    cyc();
    enable = 1'b0;
    chk("frz2 pending", 32'(pending), 32'h0100);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("frz2 no issue", 32'(valid), 32'h0);
      chk("frz2 pending held", 32'(pending), 32'h0100);
      chk("frz2 cnt held", 32'(coalesce_cnt), 32'd255);
    end
    enable = 1'b1;
    req    = 15'h0000;
    cyc();
    chk("frz2 code 9", 32'(code_out), 32'd9);
    cyc();
    chk("frz2 idle", 32'(valid), 32'h0);

    // full pending register, back-to-back issue
    req = 15'h7FFF;
    cyc();
    req = 15'h0000;
    chk("full pending", 32'(pending), 32'h7FFF);
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk("full code", 32'(code_out), 32'(i));
      chk("full valid", 32'(valid), 32'h1);
    end
    cyc();
    chk("full empty", 32'(valid), 32'h0);

    // reset in the middle of SEND
    ready = 1'b0;
    req   = 15'h0003;
    cyc();
    req = 15'h0000;
    cyc();
    chk("rst code 1", 32'(code_out), 32'd1);
    chk("rst pending", 32'(pending), 32'h2);
    rst_n = 1'b0;
    ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    ready = 1'b0;
    chk("rst valid", 32'(valid), 32'h0);
    chk("rst pending clr", 32'(pending), 32'h0);
    chk("rst code clr", 32'(code_out), 32'h0);
    chk("rst cnt clr", 32'(coalesce_cnt), 32'h0);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
